// File: rtl/key_debounce.sv
// Per-line 2-flop synchronizer plus stability-counter debouncer for active-low keys; optional KEY_EDGE_EN adds press/release pulses.
// Latency DEBOUNCE_CYCLES+2 edges from first sampling edge to keys_n_out; no backpressure, output is a level.
module key_debounce #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int CNT_W           = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] keys_n_in,
   output logic [N_KEYS-1:0] keys_n_out,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] s1;
   logic [N_KEYS-1:0] s2;
   logic [CNT_W-1:0]  cnt [N_KEYS];
   logic [N_KEYS-1:0] fire;

   // fire[i]: the synced level has now disagreed with the output for the full window
   always_comb begin
      fire = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         fire[i] = (s2[i] != keys_n_out[i]) && (cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1         <= '1;
         s2         <= '1;
         keys_n_out <= '1;
         for (int i = 0; i < N_KEYS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1 <= keys_n_in;
         s2 <= s1;
         for (int i = 0; i < N_KEYS; i++) begin
            if (s2[i] == keys_n_out[i]) begin
               cnt[i] <= '0;
            end else if (fire[i]) begin
               cnt[i]        <= '0;
               keys_n_out[i] <= s2[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef KEY_EDGE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         press_pulse   <= '0;
         release_pulse <= '0;
      end else begin
         press_pulse   <= fire & keys_n_out;
         release_pulse <= fire & ~keys_n_out;
      end
   end
`else
   assign press_pulse   = '0;
   assign release_pulse = '0;
`endif

endmodule
